// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch front end.
// Entry structs are packed so they can travel through generic FIFOs as flat vectors.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // live sits in bit 0 so a FIFO can clear it across all entries at once.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            live;
    } outstanding_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and a clear-bit-0-of-every-entry operation.
// Flush wins over push and pop in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_clr_lsb,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_push = i_push && !i_flush && ((r_count != FULL_CNT) || w_pop);

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_clr_lsb) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i][0] <= 1'b0;
                end
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: owns the fetch PC, issues credit-limited word requests,
// and buffers in-order responses with their PCs; a redirect squashes everything in flight.
module instr_prefetch
    import core_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both high.
    // Once req_valid rises it holds, with req_addr stable, until accepted; rsp_valid
    // is always accepted; instr_valid/instr_data/instr_pc hold until instr_ready.

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    logic         r_req_valid;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_fetch_pc;
    logic         r_req_stale;

    logic         w_fire;
    logic         w_out_live;
    outstanding_t w_out_wdata;
    outstanding_t w_out_head;
    logic [CW-1:0] w_out_count;
    logic [CW-1:0] w_out_count_nxt;

    logic         w_ifq_push;
    logic         w_ifq_pop;
    fetch_entry_t w_ifq_wdata;
    fetch_entry_t w_ifq_head;
    logic [CW-1:0] w_ifq_count;
    logic [CW-1:0] w_ifq_count_nxt;

    logic         w_credit_ok;
    logic         w_issue;
    logic [31:0]  w_pc_base;

    assign w_fire = r_req_valid && req_ready;

    // A request presented before a redirect belongs to the squashed path.
    assign w_out_live     = !(redirect_valid || r_req_stale);
    assign w_out_wdata.pc   = r_req_addr;
    assign w_out_wdata.live = w_out_live;

    sync_fifo #(
        .WIDTH ($bits(outstanding_t)),
        .DEPTH (DEPTH)
    ) u_outstanding (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (1'b0),
        .i_clr_lsb (redirect_valid),
        .i_push    (w_fire),
        .i_data    (w_out_wdata),
        .i_pop     (rsp_valid),
        .o_data    (w_out_head),
        .o_count   (w_out_count)
    );

    assign w_ifq_push        = rsp_valid && w_out_head.live && !redirect_valid;
    assign w_ifq_pop         = instr_valid && instr_ready && !redirect_valid;
    assign w_ifq_wdata.pc    = w_out_head.pc;
    assign w_ifq_wdata.instr = rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (redirect_valid),
        .i_clr_lsb (1'b0),
        .i_push    (w_ifq_push),
        .i_data    (w_ifq_wdata),
        .i_pop     (w_ifq_pop),
        .o_data    (w_ifq_head),
        .o_count   (w_ifq_count)
    );

    // Credits are evaluated on next-cycle occupancy so back-to-back issue is possible.
    always_comb begin
        w_out_count_nxt = w_out_count + CW'(w_fire) - CW'(rsp_valid && (w_out_count != '0));
        if (redirect_valid) begin
            w_ifq_count_nxt = '0;
        end else begin
            w_ifq_count_nxt = w_ifq_count + CW'(w_ifq_push) - CW'(w_ifq_pop);
        end
        w_credit_ok = ({1'b0, w_out_count_nxt} + {1'b0, w_ifq_count_nxt}) < DEPTH_SUM;
        w_pc_base   = redirect_valid ? word_align(redirect_pc) : r_fetch_pc;
        w_issue     = (!r_req_valid || w_fire) && w_credit_ok;
    end

    // r_fetch_pc is the address the next newly issued request will carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
            r_req_stale <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= w_pc_base;
                r_fetch_pc  <= w_pc_base + 32'(INSTR_BYTES);
            end else begin
                r_fetch_pc <= w_pc_base;
                if (w_fire) begin
                    r_req_valid <= 1'b0;
                end
            end
            if (w_fire) begin
                r_req_stale <= 1'b0;
            end else if (redirect_valid && r_req_valid) begin
                r_req_stale <= 1'b1;
            end
        end
    end

    assign req_valid   = r_req_valid;
    assign req_addr    = r_req_addr;
    assign instr_valid = (w_ifq_count != '0);
    assign instr_data  = w_ifq_head.instr;
    assign instr_pc    = w_ifq_head.pc;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus random traffic against a
// queue-based model of the expected instruction stream.
module tb_instr_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    instr_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        bit          live;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];

    logic [31:0] log_issue[$];
    bit          log_live[$];
    int          log_cyc[$];
    logic [31:0] log_deliv[$];
    int          log_dcyc[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          started = 0;
    bit          prev_rst = 1;
    bit          prev_hold = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] model_fetch = RESET_PC;
    bit          pres_stale = 0;

    bit          p_rst_n = 0;
    bit          p_req_ready = 0;
    bit          p_instr_ready = 0;
    bit          p_redirect = 0;
    logic [31:0] p_redirect_pc = '0;
    int          p_lat = 1;
    bit          p_rsp_en = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [31:0] issue_at(input int i);
        return (i < log_issue.size()) ? log_issue[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] deliv_at(input int i);
        return (i < log_deliv.size()) ? log_deliv[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        log_issue.delete();
        log_live.delete();
        log_cyc.delete();
        log_deliv.delete();
        log_dcyc.delete();
    endtask

    // One cycle: compare outputs against the model, drive inputs, advance the model.
    task automatic step();
        bit          fire;
        bit          hs;
        bit          rsp;
        bit          live;
        mreq_t       e;
        logic [63:0] hd;
        @(negedge clk);
        if (started) begin
            if (prev_rst) begin
                check("reset req_valid", {31'b0, req_valid}, 32'd0);
                check("reset instr_valid", {31'b0, instr_valid}, 32'd0);
                check("reset req_addr", req_addr, RESET_PC);
                check("reset instr_data", instr_data, 32'd0);
                check("reset instr_pc", instr_pc, 32'd0);
            end else begin
                check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    hd = exp_q[0];
                    check("instr_pc", instr_pc, hd[63:32]);
                    check("instr_data", instr_data, hd[31:0]);
                end
                check("req_valid credit", {31'b0, req_valid},
                      {31'b0, (mem_q.size() + exp_q.size()) < DEPTH});
                if (prev_hold) begin
                    check("req_valid hold", {31'b0, req_valid}, 32'd1);
                    check("req_addr hold", req_addr, prev_addr);
                end
            end
        end

        // driver
        rst_n          = p_rst_n;
        req_ready      = p_req_ready;
        instr_ready    = p_instr_ready;
        redirect_valid = p_redirect && p_rst_n;
        redirect_pc    = p_redirect_pc;
        rsp = p_rst_n && p_rsp_en && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        rsp_valid = rsp;
        rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;

        // model
        if (!p_rst_n) begin
            mem_q.delete();
            exp_q.delete();
            model_fetch = RESET_PC;
            pres_stale  = 0;
            prev_hold   = 0;
            prev_rst    = 1;
        end else begin
            fire = (req_valid === 1'b1) && p_req_ready;
            hs   = (instr_valid === 1'b1) && p_instr_ready;
            if (hs && !p_redirect) begin
                log_deliv.push_back(instr_pc);
                log_dcyc.push_back(cyc);
                if (exp_q.size() != 0) exp_q.delete(0);
            end
            if (rsp) begin
                e = mem_q.pop_front();
                if (e.live && !p_redirect) exp_q.push_back({e.pc, mem_word(e.addr)});
            end
            if (fire) begin
                live   = !(p_redirect || pres_stale);
                e.addr = req_addr;
                e.pc   = model_fetch;
                if (live) begin
                    check("req_addr seq", req_addr, model_fetch);
                    model_fetch += 4;
                end
                e.due  = cyc + p_lat;
                e.live = live;
                mem_q.push_back(e);
                log_issue.push_back(req_addr);
                log_live.push_back(live);
                log_cyc.push_back(cyc);
                pres_stale = 0;
            end
            if (p_redirect) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 0;
                model_fetch = {p_redirect_pc[31:2], 2'b00};
                if ((req_valid === 1'b1) && !fire) pres_stale = 1;
            end
            prev_hold = (req_valid === 1'b1) && !p_req_ready;
            prev_addr = req_addr;
            prev_rst  = 0;
        end
        started = 1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        p_rst_n    = 0;
        p_redirect = 0;
        steps(2);
        p_rst_n = 1;
        step();
        clear_logs();
    endtask

    initial begin
        bit found;
        int hits;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        instr_ready    = 1'b0;

        // streaming with single-cycle memory
        p_req_ready = 1; p_instr_ready = 1; p_lat = 1; p_rsp_en = 1;
        do_reset();
        steps(12);
        check("stream issue0", issue_at(0), 32'h0);
        check("stream issue1", issue_at(1), 32'h4);
        check("stream issue2", issue_at(2), 32'h8);
        check("stream deliv0", deliv_at(0), 32'h0);
        check("stream deliv1", deliv_at(1), 32'h4);
        check("stream deliv2", deliv_at(2), 32'h8);
        check("stream issue rate", (log_cyc.size() > 2) ? 32'(log_cyc[2] - log_cyc[0]) : 32'hffff_ffff, 32'd2);
        check("stream deliv rate", (log_dcyc.size() > 2) ? 32'(log_dcyc[2] - log_dcyc[0]) : 32'hffff_ffff, 32'd2);

        // back-pressure from decode limits outstanding+buffered to DEPTH
        p_instr_ready = 0;
        do_reset();
        steps(10);
        check("credit issue count", 32'(log_issue.size()), 32'd4);
        check("credit req_valid low", {31'b0, req_valid}, 32'd0);
        p_instr_ready = 1;
        step();
        p_instr_ready = 0;
        steps(6);
        check("credit after consume", 32'(log_issue.size()), 32'd5);

        // redirect while a request is stalled
        p_instr_ready = 1;
        do_reset();
        steps(4);
        clear_logs();
        p_req_ready = 0;
        step();
        log_deliv.delete();
        p_redirect = 1; p_redirect_pc = 32'h0000_0103;
        step();
        p_redirect = 0;
        step();
        p_req_ready = 1;
        steps(10);
        check("stall held addr", issue_at(0), 32'h10);
        check("stall held stale", (log_live.size() > 0) ? {31'b0, log_live[0]} : 32'hx, 32'd0);
        check("stall next addr", issue_at(1), 32'h100);
        check("stall first deliv", deliv_at(0), 32'h100);

        // redirect with several requests in flight at 3-cycle latency
        p_lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (log_issue.size() != 0 && log_issue[log_issue.size()-1] == 32'h18) found = 1;
        end
        check("inflight reach 0x18", {31'b0, found}, 32'd1);
        log_deliv.delete();
        p_redirect = 1; p_redirect_pc = 32'h0000_0040;
        step();
        p_redirect = 0;
        steps(25);
        check("inflight deliv0", deliv_at(0), 32'h40);
        check("inflight deliv1", deliv_at(1), 32'h44);
        hits = 0;
        foreach (log_deliv[i]) if (log_deliv[i] >= 32'h10 && log_deliv[i] <= 32'h18) hits++;
        check("inflight squashed", 32'(hits), 32'd0);

        // redirect, response and decode handshake in one cycle
        p_lat = 1;
        do_reset();
        steps(8);
        log_deliv.delete();
        p_redirect = 1; p_redirect_pc = 32'h0000_0200;
        step();
        @(posedge clk);
        #1;
        check("flush instr_valid", {31'b0, instr_valid}, 32'd0);
        p_redirect = 0;
        steps(10);
        check("flush first deliv", deliv_at(0), 32'h200);

        // reset with a full buffer
        p_instr_ready = 0;
        do_reset();
        steps(10);
        p_rst_n = 0;
        step();
        @(posedge clk);
        #1;
        check("midreset instr_valid", {31'b0, instr_valid}, 32'd0);
        check("midreset req_valid", {31'b0, req_valid}, 32'd0);
        p_rst_n = 1;
        step();
        clear_logs();
        steps(4);
        check("midreset first addr", issue_at(0), RESET_PC);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            p_req_ready   = ($urandom_range(0, 3) != 0);
            p_instr_ready = (n % 1000 < 700) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            p_rsp_en      = ($urandom_range(0, 4) != 0);
            p_lat         = $urandom_range(1, 4);
            p_redirect    = ($urandom_range(0, 19) == 0);
            p_redirect_pc = $urandom;
            p_rst_n       = ($urandom_range(0, 499) != 0);
            step();
        end
        p_rst_n = 1; p_redirect = 0;
        steps(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
